// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: synchronises one raw peripheral interrupt and
// forwards a single held request, level- or edge-triggered.
module plic_gateway #(
    parameter int EDGE_TRIGGERED = 0,
    parameter int SYNC_STAGES    = 2,
    parameter int MAX_PENDING    = 7,
    parameter int CW             = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rawIrq,
    input  logic          interruptComplete,
    input  logic          clearOverflow,
    output logic          signal,
    output logic [CW-1:0] pendingCount,
    output logic          overflow
);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    localparam bit          EDGE   = (EDGE_TRIGGERED != 0);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_PENDING);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   syncLevel;
    logic                   prevLevel;
    logic                   rise;

    state_t                 state;
    state_t                 state_d;
    logic [CW-1:0]          cnt_d;
    logic                   ovf_d;
    logic                   at_max;
    logic                   nonzero;
    logic                   inc;
    logic                   dec;

    assign syncLevel = sync_q[SYNC_STAGES-1];
    assign rise      = syncLevel & ~prevLevel;
    assign at_max    = (pendingCount == MAX_C);
    assign nonzero   = (pendingCount != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            prevLevel <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rawIrq};
            prevLevel <= syncLevel;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = pendingCount;
        ovf_d   = 1'b0;
        inc     = EDGE & rise & ~at_max;
        dec     = EDGE & (state == IDLE) & nonzero;

        case (state)
            IDLE: begin
                if (EDGE ? nonzero : syncLevel)
                    state_d = REQ;
            end
            REQ: begin
                if (interruptComplete)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (inc && !dec)
            cnt_d = pendingCount + CW'(1);
        else if (dec && !inc)
            cnt_d = pendingCount - CW'(1);

        // a dropped edge outranks a coincident clear
        if (EDGE)
            ovf_d = (rise & at_max) | (overflow & ~clearOverflow);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            signal       <= 1'b0;
            pendingCount <= '0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_d;
            signal       <= (state_d == REQ);
            pendingCount <= cnt_d;
            overflow     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Directed bench for plic_gateway: one level-mode and one edge-mode
// (MAX_PENDING=3) instance driven in a single linear sequence.
module tb_plic_gateway;

    logic       clk = 1'b0;
    logic       reset;
    logic       raw_l, ic_l, clr_l;
    logic       raw_e, ic_e, clr_e;
    logic       sig_l, ovf_l;
    logic       sig_e, ovf_e;
    logic [2:0] pc_l;
    logic [1:0] pc_e;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    plic_gateway #(
        .EDGE_TRIGGERED(0),
        .SYNC_STAGES   (2),
        .MAX_PENDING   (7)
    ) u_lvl (
        .clk              (clk),
        .reset            (reset),
        .rawIrq           (raw_l),
        .interruptComplete(ic_l),
        .clearOverflow    (clr_l),
        .signal           (sig_l),
        .pendingCount     (pc_l),
        .overflow         (ovf_l)
    );

    plic_gateway #(
        .EDGE_TRIGGERED(1),
        .SYNC_STAGES   (2),
        .MAX_PENDING   (3)
    ) u_edge (
        .clk              (clk),
        .reset            (reset),
        .rawIrq           (raw_e),
        .interruptComplete(ic_e),
        .clearOverflow    (clr_e),
        .signal           (sig_e),
        .pendingCount     (pc_e),
        .overflow         (ovf_e)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic edge_pulse();
        raw_e = 1'b1;
        tick(2);
        raw_e = 1'b0;
        tick(2);
    endtask

    initial begin
        reset = 1'b0;
        raw_l = 0; ic_l = 0; clr_l = 0;
        raw_e = 0; ic_e = 0; clr_e = 0;
        tick(2);
        chk("rst_sig_l", sig_l, 0);
        chk("rst_pc_l", pc_l, 0);
        chk("rst_sig_e", sig_e, 0);
        chk("rst_pc_e", pc_e, 0);
        chk("rst_ovf_e", ovf_e, 0);
        reset = 1'b1;
        tick(1);

        // level basic: rawIrq set before edge 0
        raw_l = 1'b1;
        tick(2);
        chk("lvl_sig_e1", sig_l, 0);
        tick(1);
        chk("lvl_sig_e2", sig_l, 1);
        tick(3);
        ic_l = 1'b1;
        tick(1);
        ic_l = 1'b0;
        chk("lvl_cpl_low", sig_l, 0);
        tick(1);
        chk("lvl_rereq", sig_l, 1);

        // level release while in REQ
        raw_l = 1'b0;
        tick(4);
        chk("lvl_hold", sig_l, 1);
        ic_l = 1'b1;
        tick(1);
        ic_l = 1'b0;
        chk("lvl_rel_low", sig_l, 0);
        tick(3);
        chk("lvl_rel_stay", sig_l, 0);
        chk("lvl_pc_zero", pc_l, 0);
        chk("lvl_ovf_zero", ovf_l, 0);

        // edge counting
        raw_e = 1'b1;
        tick(2);
        raw_e = 1'b0;
        chk("edg_sig_a1", sig_e, 0);
        tick(1);
        chk("edg_pc_a2", pc_e, 1);
        chk("edg_sig_a2", sig_e, 0);
        tick(1);
        chk("edg_sig_a3", sig_e, 1);
        chk("edg_pc_a3", pc_e, 0);
        edge_pulse();
        edge_pulse();
        chk("edg_pc_two", pc_e, 2);
        chk("edg_sig_two", sig_e, 1);

        ic_e = 1'b1;
        tick(1);
        ic_e = 1'b0;
        chk("edg_c1_low", sig_e, 0);
        chk("edg_c1_pc", pc_e, 2);
        tick(1);
        chk("edg_c1_re", sig_e, 1);
        chk("edg_c1_pc1", pc_e, 1);
        ic_e = 1'b1;
        tick(1);
        ic_e = 1'b0;
        tick(1);
        chk("edg_c2_re", sig_e, 1);
        chk("edg_c2_pc0", pc_e, 0);
        ic_e = 1'b1;
        tick(1);
        ic_e = 1'b0;
        chk("edg_c3_low", sig_e, 0);
        tick(2);
        chk("edg_c3_idle", sig_e, 0);
        chk("edg_c3_pc", pc_e, 0);

        // complete while idle is ignored
        ic_e = 1'b1;
        tick(1);
        ic_e = 1'b0;
        chk("edg_idle_cpl", sig_e, 0);

        // saturation
        edge_pulse();
        chk("sat_req", sig_e, 1);
        repeat (5) edge_pulse();
        chk("sat_pc", pc_e, 3);
        chk("sat_ovf", ovf_e, 1);
        clr_e = 1'b1;
        tick(1);
        clr_e = 1'b0;
        chk("sat_clr_ovf", ovf_e, 0);
        chk("sat_clr_pc", pc_e, 3);

        // clear coincident with a saturating edge: set wins
        raw_e = 1'b1;
        tick(2);
        clr_e = 1'b1;
        tick(1);
        clr_e = 1'b0;
        raw_e = 1'b0;
        chk("sim_ovf", ovf_e, 1);
        tick(2);
        chk("sim_ovf_hold", ovf_e, 1);
        chk("sim_pc", pc_e, 3);

        // complete held two cycles: second cycle is in IDLE
        ic_e = 1'b1;
        tick(1);
        chk("hold_low", sig_e, 0);
        tick(1);
        ic_e = 1'b0;
        chk("hold_re", sig_e, 1);
        chk("hold_pc", pc_e, 2);

        // edge lands as FSM leaves IDLE with count 1
        ic_e = 1'b1;
        tick(1);
        ic_e = 1'b0;
        tick(1);
        chk("pre_pc1", pc_e, 1);
        raw_e = 1'b1;
        tick(1);
        ic_e = 1'b1;
        tick(1);
        ic_e = 1'b0;
        chk("coin_low", sig_e, 0);
        chk("coin_pc_a", pc_e, 1);
        tick(1);
        raw_e = 1'b0;
        chk("coin_sig", sig_e, 1);
        chk("coin_pc_b", pc_e, 1);
        tick(2);
        edge_pulse();
        chk("ar_pre_pc", pc_e, 2);
        chk("ar_pre_sig", sig_e, 1);

        // async reset between edges
        #2;
        reset = 1'b0;
        #1;
        chk("ar_sig", sig_e, 0);
        chk("ar_pc", pc_e, 0);
        chk("ar_ovf", ovf_e, 0);
        tick(1);
        reset = 1'b1;
        tick(4);
        chk("ar_after", sig_e, 0);
        chk("ar_after_pc", pc_e, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
